// File: rtl/route_pkg.sv
// Shared defaults and width helper for the class-routed arbiter and its output FIFOs.
package route_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLASS_W = 1;
    localparam int DEF_N_IN    = 2;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_AE_TH   = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/route_fifo.sv
// One output FIFO with registered count, decoded status flags, pause hysteresis and sticky error.
module route_fifo
    import route_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_TH  = DEPTH - 1,
    parameter int AE_TH  = DEF_AE_TH
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              pause,
    output logic              error
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pause_q, pause_d;
    logic              error_q, error_d;
    logic              push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q != DEPTH_C);
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        error_d  = error_q | (pop && (count_q == '0)) | (push && (count_q == DEPTH_C));
        // Pause follows the count being loaded so the grant that reaches AF_TH is the last one.
        pause_d  = pause_q;
        if (count_d >= AF_C) begin
            pause_d = 1'b1;
        end else if (count_d <= AE_C) begin
            pause_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pause_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pause_q  <= pause_d;
            error_q  <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign pause        = pause_q;
    assign error        = error_q;
    assign rd_data      = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/route_arb.sv
// Routes words from N_IN upstream FIFOs into 2**CLASS_W output FIFOs by class,
// with one round-robin arbiter per output FIFO and zero-cycle accept.
module route_arb
    import route_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLASS_W = DEF_CLASS_W,
    parameter int N_IN    = DEF_N_IN,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int AF_TH   = DEPTH - 1,
    parameter int AE_TH   = DEF_AE_TH,
    localparam int N_OUT  = 2 ** CLASS_W
)
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_IN*(DATA_W+CLASS_W)-1:0]  in_data,
    input  logic [N_IN-1:0]                   in_empty,
    output logic [N_IN-1:0]                   in_pop,
    input  logic [N_OUT-1:0]                  out_pop,
    output logic [N_OUT*DATA_W-1:0]           out_data,
    output logic [N_OUT-1:0]                  fifo_empty,
    output logic [N_OUT-1:0]                  fifo_full,
    output logic [N_OUT-1:0]                  almost_full,
    output logic [N_OUT-1:0]                  almost_empty,
    output logic [N_OUT-1:0]                  fifo_pause,
    output logic [N_OUT-1:0]                  fifo_error,
    output logic                              Error
);

    localparam int IN_W = DATA_W + CLASS_W;
    localparam int RR_W = (N_IN > 1) ? clog2(N_IN) : 1;

    logic [CLASS_W-1:0] in_class   [N_IN];
    logic [DATA_W-1:0]  in_payload [N_IN];
    logic [N_IN-1:0]    req        [N_OUT];
    logic [N_IN-1:0]    grant      [N_OUT];
    logic [RR_W-1:0]    rr_q       [N_OUT];
    logic [RR_W-1:0]    rr_d       [N_OUT];
    logic [N_OUT-1:0]   push;
    logic [DATA_W-1:0]  push_data  [N_OUT];

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            in_class[i]   = in_data[i*IN_W + DATA_W +: CLASS_W];
            in_payload[i] = in_data[i*IN_W +: DATA_W];
        end
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            req[j] = '0;
            for (int i = 0; i < N_IN; i++) begin
                req[j][i] = !reset && !in_empty[i] && (in_class[i] == CLASS_W'(j))
                            && !fifo_pause[j] && !fifo_full[j];
            end
        end
    end

    // Each input carries one class, so the per-output grants never overlap on an input.
    always_comb begin : arb_comb
        int idx;
        idx    = 0;
        in_pop = '0;
        for (int j = 0; j < N_OUT; j++) begin
            grant[j]     = '0;
            push[j]      = 1'b0;
            push_data[j] = '0;
            rr_d[j]      = rr_q[j];
            for (int k = 0; k < N_IN; k++) begin
                idx = (int'(rr_q[j]) + k) % N_IN;
                if (!push[j] && req[j][idx]) begin
                    grant[j][idx] = 1'b1;
                    push[j]       = 1'b1;
                    push_data[j]  = in_payload[idx];
                    rr_d[j]       = RR_W'((idx + 1) % N_IN);
                end
            end
            in_pop = in_pop | grant[j];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < N_OUT; j++) begin
                rr_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                rr_q[j] <= rr_d[j];
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_fifo
        route_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AF_TH  (AF_TH),
            .AE_TH  (AE_TH)
        ) u_fifo (
            .clk          (clk),
            .reset        (reset),
            .push         (push[j]),
            .push_data    (push_data[j]),
            .pop          (out_pop[j]),
            .rd_data      (out_data[j*DATA_W +: DATA_W]),
            .empty        (fifo_empty[j]),
            .full         (fifo_full[j]),
            .almost_full  (almost_full[j]),
            .almost_empty (almost_empty[j]),
            .pause        (fifo_pause[j]),
            .error        (fifo_error[j])
        );
    end

    assign Error = |fifo_error;

endmodule

// File: tb/tb_route_arb.sv
// Bench for route_arb at default parameters: directed scenarios plus random traffic
// against a queue-based reference model of routing, round-robin, FIFO flags and pause.
module tb_route_arb;

    localparam int DATA_W  = 8;
    localparam int CLASS_W = 1;
    localparam int N_IN    = 2;
    localparam int N_OUT   = 2;
    localparam int DEPTH   = 4;
    localparam int AF_TH   = 3;
    localparam int AE_TH   = 1;
    localparam int IN_W    = DATA_W + CLASS_W;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [N_IN*IN_W-1:0]       in_data;
    logic [N_IN-1:0]            in_empty;
    logic [N_IN-1:0]            in_pop;
    logic [N_OUT-1:0]           out_pop;
    logic [N_OUT*DATA_W-1:0]    out_data;
    logic [N_OUT-1:0]           fifo_empty, fifo_full, almost_full, almost_empty, fifo_pause, fifo_error;
    logic                       err_any;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq [N_OUT][$];
    int         rr [N_OUT];
    bit         m_pause [N_OUT];
    bit         m_err [N_OUT];

    always #5 clk = ~clk;

    route_arb #(
        .DATA_W(DATA_W), .CLASS_W(CLASS_W), .N_IN(N_IN),
        .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_empty     (in_empty),
        .in_pop       (in_pop),
        .out_pop      (out_pop),
        .out_data     (out_data),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_pause   (fifo_pause),
        .fifo_error   (fifo_error),
        .Error        (err_any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_IN-1:0] model_grants(input logic [N_IN-1:0] emp,
                                                     input logic [N_IN*IN_W-1:0] data,
                                                     input logic rst);
        logic [N_IN-1:0] g;
        int  idx;
        bit  found;
        g = '0;
        if (rst) return g;
        for (int j = 0; j < N_OUT; j++) begin
            found = 0;
            if (!m_pause[j] && mq[j].size() < DEPTH) begin
                for (int k = 0; k < N_IN; k++) begin
                    idx = (rr[j] + k) % N_IN;
                    if (!found && !emp[idx] && int'(data[idx*IN_W + DATA_W]) == j) begin
                        g[idx] = 1'b1;
                        found  = 1;
                        rr[j]  = rr[j];
                    end
                end
            end
        end
        return g;
    endfunction

    task automatic model_edge(input logic rst, input logic [N_IN-1:0] g,
                              input logic [N_IN*IN_W-1:0] data, input logic [N_OUT-1:0] opop);
        int j;
        if (rst) begin
            for (int k = 0; k < N_OUT; k++) begin
                mq[k].delete();
                rr[k] = 0;
                m_pause[k] = 0;
                m_err[k] = 0;
            end
            return;
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (opop[k]) begin
                if (mq[k].size() == 0) m_err[k] = 1;
                else void'(mq[k].pop_front());
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            if (g[i]) begin
                j = int'(data[i*IN_W + DATA_W]);
                mq[j].push_back(data[i*IN_W +: DATA_W]);
                rr[j] = (i + 1) % N_IN;
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (mq[k].size() >= AF_TH) m_pause[k] = 1;
            else if (mq[k].size() <= AE_TH) m_pause[k] = 0;
        end
    endtask

    task automatic check_status();
        logic [N_OUT-1:0] e_emp, e_full, e_af, e_ae, e_pause, e_err;
        int n;
        for (int j = 0; j < N_OUT; j++) begin
            n = mq[j].size();
            e_emp[j]   = (n == 0);
            e_full[j]  = (n == DEPTH);
            e_af[j]    = (n >= AF_TH);
            e_ae[j]    = (n <= AE_TH);
            e_pause[j] = m_pause[j];
            e_err[j]   = m_err[j];
            if (n != 0) chk($sformatf("out_data%0d", j), out_data[j*DATA_W +: DATA_W], mq[j][0]);
        end
        chk("fifo_empty", fifo_empty, e_emp);
        chk("fifo_full", fifo_full, e_full);
        chk("almost_full", almost_full, e_af);
        chk("almost_empty", almost_empty, e_ae);
        chk("fifo_pause", fifo_pause, e_pause);
        chk("fifo_error", fifo_error, e_err);
        chk("Error", err_any, |e_err);
    endtask

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic cycle(input logic [N_IN-1:0] want_pop, input bit use_want);
        logic [N_IN-1:0] g;
        #1;
        g = model_grants(in_empty, in_data, reset);
        chk("in_pop", in_pop, g);
        if (use_want) chk("in_pop_directed", in_pop, want_pop);
        check_status();
        @(posedge clk);
        model_edge(reset, g, in_data, out_pop);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_empty = '1;
        out_pop  = '0;
        cycle('0, 1);
        reset    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_empty = '1;
        in_data  = '0;
        out_pop  = '0;
        @(negedge clk);
        do_reset();
        #1;
        chk("out_data_reset", out_data, 16'h0000);
        chk("empty_reset", fifo_empty, 2'b11);
        chk("ae_reset", almost_empty, 2'b11);

        // Single class-0 word from in0
        in_data  = {1'b0, 8'h11, 1'b0, 8'hA5};
        in_empty = 2'b10;
        cycle(2'b01, 1);
        in_empty = 2'b11;
        #1;
        chk("a5_head", out_data[7:0], 8'hA5);
        chk("a5_nonempty", fifo_empty[0], 1'b0);
        cycle('0, 1);

        // Two class-0 sources: alternation, pause at 3, release at 1
        do_reset();
        in_data  = {1'b0, 8'hB2, 1'b0, 8'hB1};
        in_empty = 2'b00;
        cycle(2'b01, 1);
        cycle(2'b10, 1);
        cycle(2'b01, 1);
        cycle(2'b00, 1);
        cycle(2'b00, 1);
        out_pop = 2'b01;
        cycle(2'b00, 1);
        cycle(2'b00, 1);
        out_pop = 2'b00;
        cycle(2'b10, 1);

        // Push and pop together at count 2
        out_pop = 2'b01;
        cycle(2'b01, 1);
        out_pop  = 2'b00;
        in_empty = 2'b11;
        #1;
        chk("pp_af", almost_full[0], 1'b0);
        chk("pp_ae", almost_empty[0], 1'b0);
        cycle('0, 1);

        // Parallel grants to distinct outputs
        do_reset();
        in_data  = {1'b1, 8'h3C, 1'b0, 8'h5A};
        in_empty = 2'b00;
        cycle(2'b11, 1);
        in_empty = 2'b11;
        #1;
        chk("par_data", out_data, 16'h3C5A);
        chk("par_empty", fifo_empty, 2'b00);
        cycle('0, 1);

        // Underflow error is sticky until reset
        do_reset();
        out_pop = 2'b10;
        cycle('0, 1);
        out_pop = 2'b00;
        #1;
        chk("err1_bit", fifo_error[1], 1'b1);
        chk("err1_any", err_any, 1'b1);
        for (int n = 0; n < 3; n++) cycle('0, 1);
        chk("err1_sticky", err_any, 1'b1);
        do_reset();
        #1;
        chk("err1_cleared", err_any, 1'b0);

        // Reset while FIFO0 holds 3 and is paused
        in_data  = {1'b0, 8'hC2, 1'b0, 8'hC1};
        in_empty = 2'b00;
        for (int n = 0; n < 4; n++) cycle('0, 0);
        #1;
        chk("pre_rst_pause", fifo_pause[0], 1'b1);
        reset = 1'b1;
        cycle('0, 1);
        reset    = 1'b0;
        in_empty = 2'b11;
        #1;
        chk("rst_empty", fifo_empty, 2'b11);
        chk("rst_pause", fifo_pause, 2'b00);
        chk("rst_error", err_any, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            in_empty   = 2'($urandom);
            in_data    = 18'($urandom);
            out_pop[0] = ($urandom_range(0, 3) == 0);
            out_pop[1] = ($urandom_range(0, 3) == 0);
            cycle('0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
